rvfi_retire_serializer: RTL and testbench

//  Merges up to NRET RVFI retire channels per cycle into one in-order stream.

---
 rtl/rvfi_retire_serializer.sv | 186 ++++++++++++++++++
 tb/tb_rvfi_retire_serializer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_retire_serializer.sv
// rvfi_retire_serializer
// Merges up to NRET RVFI retire channels per cycle into one in-order stream
// through a circular FIFO with a valid/ready output and rollback truncation.
// Optional feature macro: RISCV_FORMAL_SERIALIZER_ORDERCHK_EN adds the sticky
// order_err output that flags non-consecutive order numbers at the output.
module rvfi_retire_serializer #(
    parameter int unsigned NRET  = 1,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [NRET-1:0]          in_valid,
    input  logic [NRET*ILEN-1:0]     in_insn,
    input  logic [NRET*64-1:0]       in_order,
    input  logic [NRET-1:0]          in_trap,
    input  logic [NRET-1:0]          in_intr,
    input  logic                     rollback_valid,
    input  logic [63:0]              rollback_order,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ILEN-1:0]          out_insn,
    output logic [63:0]              out_order,
    output logic                     out_trap,
    output logic                     out_intr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef RISCV_FORMAL_SERIALIZER_ORDERCHK_EN
    ,
    output logic                     order_err
`endif
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned CHW = (NRET > 1) ? $clog2(NRET) : 1;

    // FIFO storage (not reset)
    logic [ILEN-1:0] mem_insn  [DEPTH];
    logic [63:0]     mem_order [DEPTH];
    logic            mem_trap  [DEPTH];
    logic            mem_intr  [DEPTH];

    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;

    logic            head_flush;
    logic            pop;
    logic [CW-1:0]   keep;
    logic [PW-1:0]   idx;
    logic [CW-1:0]   kept;
    logic [CW-1:0]   base_cnt;
    logic [CW-1:0]   free;
    logic [CW-1:0]   nwr;
    logic [PW-1:0]   wbase;
    logic [PW-1:0]   slot;
    logic [DEPTH-1:0] wen;
    logic [CHW-1:0]  wsel [DEPTH];

    // Head entry drives the output; a rollback covering the head hides it
    always_comb begin
        out_insn   = mem_insn[rptr_q];
        out_order  = mem_order[rptr_q];
        out_trap   = mem_trap[rptr_q];
        out_intr   = mem_intr[rptr_q];
        head_flush = rollback_valid && (mem_order[rptr_q] >= rollback_order);
        out_valid  = (count_q != '0) && !head_flush;
        pop        = out_valid && out_ready;
    end

    // Count the buffered prefix whose order lies below the rollback order
    always_comb begin
        keep = '0;
        idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rptr_q + PW'(i);
            if ((CW'(i) < count_q) && (mem_order[idx] < rollback_order)) begin
                keep = keep + CW'(1);
            end
        end
    end

    // Truncate, dequeue, then compact and enqueue valid channels into free slots
    always_comb begin
        kept       = rollback_valid ? keep : count_q;
        base_cnt   = kept - CW'(pop);
        // Truncation rebuilds wptr from rptr; kept == DEPTH wraps back to rptr
        wbase      = rollback_valid ? (rptr_q + keep[PW-1:0]) : wptr_q;
        free       = CW'(DEPTH) - base_cnt;
        nwr        = '0;
        slot       = '0;
        wen        = '0;
        overflow_d = overflow_q;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            wsel[s] = '0;
        end
        for (int unsigned c = 0; c < NRET; c++) begin
            if (in_valid[c] &&
                !(rollback_valid && (in_order[c*64 +: 64] >= rollback_order))) begin
                if (nwr < free) begin
                    slot       = wbase + nwr[PW-1:0];
                    wen[slot]  = 1'b1;
                    wsel[slot] = CHW'(c);
                    nwr        = nwr + CW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
        count_d = base_cnt + nwr;
        wptr_d  = wbase + nwr[PW-1:0];
        rptr_d  = rptr_q + PW'(pop);
    end

    // Control state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage write from the selected channel
    always_ff @(posedge clock) begin
        for (int unsigned s = 0; s < DEPTH; s++) begin
            if (wen[s]) begin
                mem_insn[s]  <= in_insn[wsel[s]*ILEN +: ILEN];
                mem_order[s] <= in_order[wsel[s]*64 +: 64];
                mem_trap[s]  <= in_trap[wsel[s]];
                mem_intr[s]  <= in_intr[wsel[s]];
            end
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef RISCV_FORMAL_SERIALIZER_ORDERCHK_EN
    logic [63:0] last_order_q, last_order_d;
    logic        seen_q, seen_d;
    logic        order_err_q, order_err_d;

    // Each pop after the first must carry last_order + 1; rollback rebases it
    always_comb begin
        last_order_d = last_order_q;
        seen_d       = seen_q;
        order_err_d  = order_err_q;
        if (pop) begin
            if (seen_q && (out_order != last_order_q + 64'd1)) begin
                order_err_d = 1'b1;
            end
            last_order_d = out_order;
            seen_d       = 1'b1;
        end
        if (rollback_valid) begin
            last_order_d = rollback_order - 64'd1;
            seen_d       = 1'b1;
        end
    end

    // Order checker state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_order_q <= '0;
            seen_q       <= 1'b0;
            order_err_q  <= 1'b0;
        end else begin
            last_order_q <= last_order_d;
            seen_q       <= seen_d;
            order_err_q  <= order_err_d;
        end
    end

    assign order_err = order_err_q;
`endif

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Scoreboard bench for rvfi_retire_serializer (NRET=2, DEPTH=4).
// The reference model is a queue of retirements; a monitor compares the DUT
// head against the queue front every cycle and pops on handshakes.
module tb_rvfi_retire_serializer;

    localparam int unsigned NRET  = 2;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic        intr;
    } ent_t;

    logic                 clock = 1'b0;
    logic                 resetn;
    logic [NRET-1:0]      in_valid;
    logic [NRET*ILEN-1:0] in_insn;
    logic [NRET*64-1:0]   in_order;
    logic [NRET-1:0]      in_trap;
    logic [NRET-1:0]      in_intr;
    logic                 rollback_valid;
    logic [63:0]          rollback_order;
    logic                 out_valid;
    logic                 out_ready;
    logic [ILEN-1:0]      out_insn;
    logic [63:0]          out_order;
    logic                 out_trap;
    logic                 out_intr;
    logic [$clog2(DEPTH):0] count;
    logic                 overflow;
`ifdef RISCV_FORMAL_SERIALIZER_ORDERCHK_EN
    logic                 order_err;
`endif

    rvfi_retire_serializer #(.NRET(NRET), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_insn(in_insn), .in_order(in_order),
        .in_trap(in_trap), .in_intr(in_intr),
        .rollback_valid(rollback_valid), .rollback_order(rollback_order),
        .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
        .out_order(out_order), .out_trap(out_trap), .out_intr(out_intr),
        .count(count), .overflow(overflow)
`ifdef RISCV_FORMAL_SERIALIZER_ORDERCHK_EN
        , .order_err(order_err)
`endif
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t mq[$];
    logic m_ovf = 1'b0;
    logic [63:0] plog[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare head against model front, pop on handshake
    always @(negedge clock) begin
        logic exp_v;
        if (resetn === 1'b1) begin
            exp_v = (mq.size() != 0) && !(rollback_valid && (mq[0].order >= rollback_order));
            chk("count", 64'(count), 64'(mq.size()));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("out_valid", 64'(out_valid), 64'(exp_v));
            if (exp_v) begin
                chk("out_order", out_order, mq[0].order);
                chk("out_insn", 64'(out_insn), 64'(mq[0].insn));
                chk("out_trap", 64'(out_trap), 64'(mq[0].trap));
                chk("out_intr", 64'(out_intr), 64'(mq[0].intr));
                if (out_ready) begin
                    plog.push_back(mq[0].order);
                    void'(mq.pop_front());
                end
            end
        end
    end

    // Apply this cycle's rollback and enqueue to the model (after monitor pop)
    task automatic model_update();
        ent_t e;
        if (rollback_valid) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].order >= rollback_order) mq.delete(i);
            end
        end
        for (int c = 0; c < int'(NRET); c++) begin
            e.order = in_order[c*64 +: 64];
            e.insn  = in_insn[c*ILEN +: ILEN];
            e.trap  = in_trap[c];
            e.intr  = in_intr[c];
            if (in_valid[c] && !(rollback_valid && (e.order >= rollback_order))) begin
                if (mq.size() < int'(DEPTH)) mq.push_back(e);
                else m_ovf = 1'b1;
            end
        end
    endtask

    // Drive one cycle of stimulus; returns 1 time unit after the posedge
    task automatic drive(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                         input logic rbv, input logic [63:0] rbo, input logic rdy);
        in_valid       = v;
        in_order       = {o1, o0};
        in_insn        = {$urandom, $urandom};
        in_trap        = 2'($urandom);
        in_intr        = 2'($urandom);
        rollback_valid = rbv;
        rollback_order = rbo;
        out_ready      = rdy;
        @(negedge clock);
        #1;
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(2'b00, 64'd0, 64'd0, 1'b0, 64'd0, rdy);
    endtask

    // Half-cycle async reset pulse between edges
    task automatic reset_pulse();
        in_valid = '0;
        rollback_valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
`ifdef RISCV_FORMAL_SERIALIZER_ORDERCHK_EN
        chk("rst_order_err", 64'(order_err), 64'd0);
`endif
        mq.delete();
        m_ovf = 1'b0;
        #2;
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] nxt;
        logic [1:0]  v;
        logic [63:0] o0, o1;
        logic        rdy;
        int          space;

        resetn = 1'b0;
        in_valid = '0; in_insn = '0; in_order = '0; in_trap = '0; in_intr = '0;
        rollback_valid = 1'b0; rollback_order = '0; out_ready = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        resetn = 1'b1;

        // 1. single retirement
        idle(1'b0);
        drive(2'b01, 64'd5, 64'd0, 1'b0, 64'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // 2. compaction and back-pressure
        drive(2'b10, 64'd99, 64'd0, 1'b0, 64'd0, 1'b0);
        drive(2'b11, 64'd1, 64'd2, 1'b0, 64'd0, 1'b0);
        idle(1'b0);
        chk("t2_count", 64'(count), 64'd3);

        // 3. overflow from count=3
        drive(2'b11, 64'd3, 64'd4, 1'b0, 64'd0, 1'b0);
        chk("t3_count", 64'(count), 64'd4);
        chk("t3_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 6; i++) idle(1'b1);
        chk("t3_overflow_sticky", 64'(overflow), 64'd1);

        // 4. rollback truncation with concurrent pop
        drive(2'b11, 64'd10, 64'd11, 1'b0, 64'd0, 1'b0);
        drive(2'b11, 64'd12, 64'd13, 1'b0, 64'd0, 1'b0);
        drive(2'b00, 64'd0, 64'd0, 1'b1, 64'd12, 1'b1);
        chk("t4_count", 64'(count), 64'd1);
        chk("t4_head", out_order, 64'd11);
        drive(2'b11, 64'd12, 64'd13, 1'b0, 64'd0, 1'b0);
        drive(2'b01, 64'd14, 64'd0, 1'b0, 64'd0, 1'b0);
        drive(2'b00, 64'd0, 64'd0, 1'b1, 64'd10, 1'b1);
        chk("t4_flush_count", 64'(count), 64'd0);

        // 5. wrap-around stream 0..19 without overflow
        reset_pulse();
        plog.delete();
        nxt = 0;
        rdy = 1'b0;
        for (int cyc = 0; cyc < 200 && (nxt < 20 || mq.size() != 0); cyc++) begin
            rdy = ~rdy;
            space = int'(DEPTH) - mq.size() + ((mq.size() != 0 && rdy) ? 1 : 0);
            if (nxt < 20 && space >= 2) begin
                drive(2'b11, nxt, nxt + 64'd1, 1'b0, 64'd0, rdy);
                nxt = nxt + 64'd2;
            end else begin
                idle(rdy);
            end
        end
        chk("wrap_len", 64'(plog.size()), 64'd20);
        for (int i = 0; i < 20 && i < plog.size(); i++) chk("wrap_seq", plog[i], 64'(i));
        chk("wrap_overflow", 64'(overflow), 64'd0);

        // 6. async reset mid-stream, then order checking
        drive(2'b11, 64'd0, 64'd1, 1'b0, 64'd0, 1'b0);
        drive(2'b01, 64'd3, 64'd0, 1'b0, 64'd0, 1'b0);
        chk("t6_count", 64'(count), 64'd3);
        reset_pulse();
        drive(2'b11, 64'd0, 64'd1, 1'b0, 64'd0, 1'b0);
        drive(2'b01, 64'd3, 64'd0, 1'b0, 64'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);
`ifdef RISCV_FORMAL_SERIALIZER_ORDERCHK_EN
        chk("order_err_clean", 64'(order_err), 64'd0);
`endif
        idle(1'b1);
`ifdef RISCV_FORMAL_SERIALIZER_ORDERCHK_EN
        chk("order_err_gap", 64'(order_err), 64'd1);
`endif

        // Random traffic with rollbacks
        nxt = 100;
        for (int cyc = 0; cyc < 500; cyc++) begin
            v  = 2'($urandom);
            o0 = nxt;
            o1 = v[0] ? nxt + 64'd1 : nxt;
            if (!v[0]) o0 = 64'($urandom);
            if (!v[1]) o1 = 64'($urandom);
            if ($urandom_range(0, 9) == 0)
                drive(v, o0, o1, 1'b1, nxt - 64'($urandom_range(0, 6)), 1'($urandom));
            else
                drive(v, o0, o1, 1'b0, 64'($urandom), 1'($urandom));
            nxt = nxt + 64'(v[0]) + 64'(v[1]);
        end
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("final_empty", 64'(count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
